// File: rtl/hydrophone_pkg.sv
// Shared types and constants for the hydrophone front end and the TDOA stage.
// Holds the channel geometry, the timestamp type and the capture state encoding.
package hydrophone_pkg;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 12;
  localparam int TS_W     = 8;

  // Metres per second; the TDOA stage converts tick differences to range with it.
  localparam int SPEED_OF_SOUND_WATER = 1500;

  typedef logic [TS_W-1:0]     ts_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam ts_t TS_NONE = '1;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LISTEN,
    REPORT,
    HOLDOFF
  } cap_state_e;

endpackage

// File: rtl/hydrophone_arrival_capture_if.sv
// Arrival-vector handshake between the capture block (master) and the TDOA stage (slave).
interface hydrophone_arrival_capture_if;
  import hydrophone_pkg::*;

  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CH*TS_W-1:0] arrival_ts;
  logic [NUM_CH-1:0]      detect_mask;
  logic                   timeout;

  modport master (
    output out_valid, arrival_ts, detect_mask, timeout,
    input  out_ready
  );

  modport slave (
    input  out_valid, arrival_ts, detect_mask, timeout,
    output out_ready
  );

endinterface

// File: rtl/hydrophone_channel_detect.sv
// One hydrophone channel: threshold compare, first-crossing flag and arrival timestamp.
// The top FSM decides when a tick may capture and when the channel is cleared.
module hydrophone_channel_detect
  import hydrophone_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    enable,
  input  sample_t threshold,
  input  sample_t sample,
  input  ts_t     ts_in,
  output logic    hit,
  output logic    latched,
  output ts_t     ts
);

  // Only the first crossing after a clear counts; later ones are echoes.
  assign hit = enable && !latched && (sample >= threshold);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched <= 1'b0;
      ts      <= TS_NONE;
    end else if (clear) begin
      latched <= 1'b0;
      ts      <= TS_NONE;
    end else if (hit) begin
      latched <= 1'b1;
      ts      <= ts_in;
    end
  end

endmodule

// File: rtl/hydrophone_arrival_capture.sv
// Captures per-channel first-arrival times relative to the earliest crossing and
// reports one vector per ping over valid/ready, then holds off before re-arming.
module hydrophone_arrival_capture
  import hydrophone_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 200,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  sample_t                    threshold,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  output logic                       busy,
  hydrophone_arrival_capture_if.master rpt
);

  localparam int            HO_W      = $clog2(HOLDOFF_CYCLES + 1);
  localparam ts_t           WINDOW_TS = ts_t'(WINDOW_SAMPLES);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  cap_state_e      state_q, state_d;
  sample_t         thr_q;
  ts_t             tick_cnt, tick_next, ts_in;
  logic [HO_W-1:0] ho_cnt;
  logic            timeout_q;
  logic            clear, enable, any_hit, all_done, ho_done;
  logic [NUM_CH-1:0] hit, latched;
  ts_t             ts_arr [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hydrophone_channel_detect u_det (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .enable    (enable),
      .threshold (thr_q),
      .sample    (sample_in[c*SAMPLE_W +: SAMPLE_W]),
      .ts_in     (ts_in),
      .hit       (hit[c]),
      .latched   (latched[c]),
      .ts        (ts_arr[c])
    );
    assign rpt.arrival_ts[c*TS_W +: TS_W] = ts_arr[c];
  end

  // Saturating so a late crossing can never wrap onto a small timestamp.
  assign tick_next = (tick_cnt == WINDOW_TS) ? tick_cnt : tick_cnt + ts_t'(1);
  assign any_hit   = |hit;
  assign all_done  = &(latched | hit);
  assign ho_done   = (ho_cnt == HO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    enable  = 1'b0;
    ts_in   = '0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          clear   = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        enable = sample_valid;
        if (any_hit) state_d = all_done ? REPORT : LISTEN;
      end
      LISTEN: begin
        enable = sample_valid;
        ts_in  = tick_next;
        if (sample_valid && (all_done || tick_next == WINDOW_TS)) state_d = REPORT;
      end
      REPORT: begin
        if (rpt.out_ready) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (ho_done) begin
          clear   = 1'b1;
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q     <= '0;
      tick_cnt  <= '0;
      ho_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == IDLE && arm) thr_q <= threshold;

      if (state_q == ARMED)                       tick_cnt <= '0;
      else if (state_q == LISTEN && sample_valid) tick_cnt <= tick_next;

      if (state_q == HOLDOFF) ho_cnt <= ho_cnt + HO_W'(1);
      else                    ho_cnt <= '0;

      if (clear)                                           timeout_q <= 1'b0;
      else if (state_q != REPORT && state_d == REPORT)     timeout_q <= !all_done;
    end
  end

  assign rpt.out_valid   = (state_q == REPORT);
  assign rpt.detect_mask = latched;
  assign rpt.timeout     = timeout_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_hydrophone_arrival_capture.sv
// Directed bench for hydrophone_arrival_capture: staggered, simultaneous, timeout,
// backpressure, holdoff/re-arm and asynchronous reset scenarios.
module tb_hydrophone_arrival_capture;
  import hydrophone_pkg::*;

  localparam int WINDOW  = 200;
  localparam int HOLDOFF = 1000;

  logic                       clk;
  logic                       rst;
  logic                       arm;
  sample_t                    threshold;
  logic                       sample_valid;
  logic [NUM_CH*SAMPLE_W-1:0] sample_in;
  logic                       busy;

  int n_checks = 0;
  int n_errors = 0;

  hydrophone_arrival_capture_if rpt_if ();

  hydrophone_arrival_capture #(
    .WINDOW_SAMPLES (WINDOW),
    .HOLDOFF_CYCLES (HOLDOFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .threshold    (threshold),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .busy         (busy),
    .rpt          (rpt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_CH*SAMPLE_W-1:0] pack4(input sample_t s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input sample_t thr);
    arm = 1'b1;
    threshold = thr;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (rpt_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b want 0", rpt_if.out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++;
    if (rpt_if.arrival_ts !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL rst_ts: got %h want ffffffff", rpt_if.arrival_ts); end
    n_checks++;
    if (rpt_if.detect_mask !== 4'h0) begin n_errors++; $display("FAIL rst_mask: got %h want 0", rpt_if.detect_mask); end
    n_checks++;
    if (rpt_if.timeout !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %0b want 0", rpt_if.timeout); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_staggered();
    int      cross_t [NUM_CH] = '{0, 3, 5, 9};
    sample_t s [NUM_CH];
    do_arm(12'd100);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL stag_busy: got %0b want 1", busy); end
    // Below-threshold tick must leave the block in ARMED.
    sample_valid = 1'b1;
    sample_in = pack4(12'd99, 12'd50, 12'd0, 12'd99);
    step();
    n_checks++;
    if (rpt_if.detect_mask !== 4'h0) begin n_errors++; $display("FAIL stag_quiet_mask: got %h want 0", rpt_if.detect_mask); end
    for (int t = 0; t <= 9; t++) begin
      for (int c = 0; c < NUM_CH; c++) s[c] = (t >= cross_t[c]) ? 12'd150 : 12'd0;
      sample_in = pack4(s[0], s[1], s[2], s[3]);
      step();
      if (t == 8) begin
        n_checks++;
        if (rpt_if.out_valid !== 1'b0 || rpt_if.detect_mask !== 4'h7) begin
          n_errors++;
          $display("FAIL stag_tick8: got valid=%0b mask=%h want valid=0 mask=7", rpt_if.out_valid, rpt_if.detect_mask);
        end
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (rpt_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL stag_valid: got %0b want 1", rpt_if.out_valid); end
    n_checks++;
    if (rpt_if.arrival_ts !== {8'd9, 8'd5, 8'd3, 8'd0}) begin n_errors++; $display("FAIL stag_ts: got %h want 09050300", rpt_if.arrival_ts); end
    n_checks++;
    if (rpt_if.detect_mask !== 4'hF) begin n_errors++; $display("FAIL stag_mask: got %h want f", rpt_if.detect_mask); end
    n_checks++;
    if (rpt_if.timeout !== 1'b0) begin n_errors++; $display("FAIL stag_timeout: got %0b want 0", rpt_if.timeout); end
  endtask

  task automatic test_backpressure();
    rpt_if.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1;
      sample_in = {16'($urandom), 32'($urandom)};
      step();
      n_checks++;
      if ({rpt_if.out_valid, rpt_if.arrival_ts, rpt_if.detect_mask, rpt_if.timeout} !==
          {1'b1, 8'd9, 8'd5, 8'd3, 8'd0, 4'hF, 1'b0}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got valid=%0b ts=%h mask=%h to=%0b want valid=1 ts=09050300 mask=f to=0",
                 i, rpt_if.out_valid, rpt_if.arrival_ts, rpt_if.detect_mask, rpt_if.timeout);
      end
    end
    rpt_if.out_ready = 1'b1;
    step();
    rpt_if.out_ready = 1'b0;
    n_checks++;
    if (rpt_if.out_valid !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_xfer: got valid=%0b busy=%0b want valid=0 busy=1", rpt_if.out_valid, busy);
    end
  endtask

  task automatic test_holdoff_rearm();
    int bad = 0;
    sample_valid = 1'b1;
    sample_in = pack4(12'd150, 12'd0, 12'd0, 12'd0);
    for (int i = 0; i < HOLDOFF - 1; i++) begin
      step();
      if (rpt_if.out_valid !== 1'b0 || rpt_if.detect_mask !== 4'hF ||
          rpt_if.arrival_ts !== {8'd9, 8'd5, 8'd3, 8'd0}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL ho_hold: got %0d bad cycles want 0", bad); end
    step();
    n_checks++;
    if (rpt_if.detect_mask !== 4'h0 || rpt_if.arrival_ts !== 32'hFFFF_FFFF || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ho_rearm: got mask=%h ts=%h busy=%0b want mask=0 ts=ffffffff busy=1",
               rpt_if.detect_mask, rpt_if.arrival_ts, busy);
    end
    step();
    n_checks++;
    if (rpt_if.detect_mask !== 4'h1 || rpt_if.arrival_ts !== 32'hFFFF_FF00) begin
      n_errors++;
      $display("FAIL ho_first: got mask=%h ts=%h want mask=1 ts=ffffff00", rpt_if.detect_mask, rpt_if.arrival_ts);
    end
  endtask

  task automatic test_reset_mid_listen();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rpt_if.out_valid !== 1'b0 || busy !== 1'b0 || rpt_if.arrival_ts !== 32'hFFFF_FFFF || rpt_if.detect_mask !== 4'h0) begin
      n_errors++;
      $display("FAIL rml_async: got valid=%0b busy=%0b ts=%h mask=%h want 0 0 ffffffff 0",
               rpt_if.out_valid, busy, rpt_if.arrival_ts, rpt_if.detect_mask);
    end
    step();
    rst = 1'b0;
    sample_valid = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rml_idle: got busy=%0b want 0", busy); end
    do_arm(12'd100);
    n_checks++;
    if (busy !== 1'b1 || rpt_if.detect_mask !== 4'h0 || rpt_if.arrival_ts !== 32'hFFFF_FFFF || rpt_if.timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL rml_rearm: got busy=%0b mask=%h ts=%h to=%0b want 1 0 ffffffff 0",
               busy, rpt_if.detect_mask, rpt_if.arrival_ts, rpt_if.timeout);
    end
  endtask

  task automatic test_simultaneous();
    sample_valid = 1'b1;
    sample_in = pack4(12'd99, 12'd150, 12'd150, 12'd0);
    step();
    for (int t = 1; t <= 7; t++) begin
      // Off-tick cycle with loud samples: must not count or capture.
      sample_valid = 1'b0;
      sample_in = pack4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      step();
      sample_valid = 1'b1;
      sample_in = (t == 7) ? pack4(12'd100, 12'd150, 12'd150, 12'hFFF)
                           : pack4(12'd99, 12'd150, 12'd150, 12'd99);
      step();
      if (t == 6) begin
        n_checks++;
        if (rpt_if.out_valid !== 1'b0 || rpt_if.detect_mask !== 4'h6) begin
          n_errors++;
          $display("FAIL sim_tick6: got valid=%0b mask=%h want valid=0 mask=6", rpt_if.out_valid, rpt_if.detect_mask);
        end
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (rpt_if.out_valid !== 1'b1 || rpt_if.arrival_ts !== {8'd7, 8'd0, 8'd0, 8'd7} ||
        rpt_if.detect_mask !== 4'hF || rpt_if.timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL sim_report: got valid=%0b ts=%h mask=%h to=%0b want 1 07000007 f 0",
               rpt_if.out_valid, rpt_if.arrival_ts, rpt_if.detect_mask, rpt_if.timeout);
    end
    rpt_if.out_ready = 1'b1;
    step();
    rpt_if.out_ready = 1'b0;
    n_checks++;
    if (rpt_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL sim_xfer: got %0b want 0", rpt_if.out_valid); end
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_arm(12'd100);
    sample_valid = 1'b1;
    for (int t = 0; t <= WINDOW; t++) begin
      // An arm with threshold 0 mid-capture must be ignored.
      arm       = (t == 100);
      threshold = (t == 100) ? 12'd0 : 12'd100;
      sample_in = pack4(12'd150, (t >= 4) ? 12'd150 : 12'd0, 12'd99, 12'd99);
      step();
      if (t == WINDOW - 1) begin
        n_checks++;
        if (rpt_if.out_valid !== 1'b0 || rpt_if.detect_mask !== 4'h3) begin
          n_errors++;
          $display("FAIL to_tick199: got valid=%0b mask=%h want valid=0 mask=3", rpt_if.out_valid, rpt_if.detect_mask);
        end
      end
    end
    arm = 1'b0;
    sample_valid = 1'b0;
    n_checks++;
    if (rpt_if.out_valid !== 1'b1 || rpt_if.timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL to_flag: got valid=%0b to=%0b want 1 1", rpt_if.out_valid, rpt_if.timeout);
    end
    n_checks++;
    if (rpt_if.arrival_ts !== {8'hFF, 8'hFF, 8'd4, 8'd0} || rpt_if.detect_mask !== 4'h3) begin
      n_errors++;
      $display("FAIL to_ts: got ts=%h mask=%h want ffff0400 3", rpt_if.arrival_ts, rpt_if.detect_mask);
    end
    rpt_if.out_ready = 1'b1;
    step();
    rpt_if.out_ready = 1'b0;
    n_checks++;
    if (rpt_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL to_xfer: got %0b want 0", rpt_if.out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    threshold = '0;
    sample_valid = 1'b0;
    sample_in = '0;
    rpt_if.out_ready = 1'b0;
    test_reset();
    test_staggered();
    test_backpressure();
    test_holdoff_rearm();
    test_reset_mid_listen();
    test_simultaneous();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hydrophone_arrival_capture.md
Name: hydrophone_arrival_capture

Overview:
- Producer side of the hydrophone-to-TDOA interface. Watches sample streams from NUM_CH hydrophones and detects the first threshold crossing on each channel.
- Timestamps each crossing relative to the earliest one, in sample ticks.
- Presents one arrival-time vector per ping to the TDOA stage over a valid/ready handshake, then holds off before re-arming.

Parameters:
- NUM_CH, 4, number of hydrophone channels.
- SAMPLE_W, 12, unsigned sample magnitude width.
- TS_W, 8, timestamp width. Must satisfy 2^TS_W - 1 > WINDOW_SAMPLES.
- WINDOW_SAMPLES, 200, sample ticks allowed after the first crossing before the capture is declared incomplete.
- HOLDOFF_CYCLES, 1000, clk cycles ignored after a report is accepted (echo rejection).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts listening from IDLE.
- threshold  in  SAMPLE_W  detection level, captured on arm.
- sample_valid  in  1  one new sample on all channels this cycle (sample tick).
- sample_in  in  NUM_CH*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
- out_valid  out  1  arrival vector available.
- out_ready  in  1  TDOA stage accepts the vector.
- arrival_ts  out  NUM_CH*TS_W  per-channel timestamp, channel c at [c*TS_W +: TS_W]. All-ones means not detected.
- detect_mask  out  NUM_CH  bit c set if channel c crossed.
- timeout  out  1  window expired before all channels crossed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, all outputs 0, arrival_ts all-ones, internal counters 0. Assertion of rst in any state, including mid-capture or mid-handshake, aborts immediately to IDLE. A pending vector is discarded.
- Crossing rule: on a sample tick, channel c crosses if sample_in[c] >= latched threshold and c is not yet latched. Comparison is unsigned.
- States:
  - IDLE: arm=1 latches threshold, clears the mask, sets all timestamps to all-ones, and moves to ARMED. arm is ignored in every other state.
  - ARMED: on a sample tick with at least one crossing, latch timestamp 0 for every crossing channel, set tick_cnt=0, and move to LISTEN. Ticks with no crossing leave the block in ARMED.
  - LISTEN: on each sample tick, tick_cnt increments first. Newly crossing channels then latch the incremented value. Channels crossing on the same tick get equal timestamps.
    - If all channels are latched, move to REPORT with timeout=0.
    - Otherwise, if the incremented tick_cnt == WINDOW_SAMPLES, move to REPORT with timeout=1. A crossing on that final tick is still latched; if it completes the mask, timeout=0.
  - REPORT: out_valid=1. arrival_ts, detect_mask and timeout are held stable while out_valid=1 and out_ready=0. Samples are ignored. When out_valid and out_ready are both high in the same cycle, move to HOLDOFF and deassert out_valid the next cycle.
  - HOLDOFF: count HOLDOFF_CYCLES clk cycles, ignoring samples, then move to ARMED. Re-arm is automatic; IDLE is reached only via rst.
- Latency: out_valid rises the clk cycle after the completing sample tick.
- Output register behaviour: the timestamp and mask registers keep their last values through HOLDOFF. They are cleared on re-entry to ARMED.
- out_ready while out_valid=0 has no effect.
- sample_valid may be high every cycle or sparse; only ticks advance tick_cnt.
- tick_cnt saturates at WINDOW_SAMPLES. It never wraps.

Decomposition:
- Shared package hydrophone_pkg:
  - NUM_CH, SAMPLE_W, TS_W.
  - Timestamp typedef ts_t.
  - TS_NONE constant (all-ones).
  - Capture state enum {IDLE, ARMED, LISTEN, REPORT, HOLDOFF}.
  - SPEED_OF_SOUND_WATER=1500, shared with the TDOA stage.
- One sub-module, hydrophone_channel_detect, instantiated NUM_CH times. Per channel it holds:
  - the threshold compare,
  - the latched flag,
  - the timestamp register,
  - clear and capture inputs driven by the top FSM.

Test Plan:
- Staggered arrivals:
  - Stimulus: threshold=100; arm; on ticks 0,3,5,9 set channels 0,1,2,3 to 150, all other samples 0.
  - Required: out_valid one cycle after tick 9; arrival_ts={9,5,3,0} (ch3..ch0); detect_mask=4'hF; timeout=0.
- Simultaneous crossing:
  - Stimulus: channels 1 and 2 cross on the first tick; channels 0 and 3 cross 7 ticks later.
  - Required: ts ch0..ch3={7,0,0,7}; mask=F.
- Timeout:
  - Stimulus: WINDOW_SAMPLES=200; only channels 0 and 1 cross, at ticks 0 and 4.
  - Required: REPORT after tick 200; ts={FF,FF,4,0}; mask=4'h3; timeout=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles while new samples are toggled.
  - Required: outputs stable for all 20 cycles; one transfer when out_ready=1; out_valid low the next cycle.
- Holdoff and re-arm:
  - Stimulus: after a transfer, drive above-threshold samples for HOLDOFF_CYCLES cycles.
  - Required: no capture during that period; the first crossing after holdoff starts a new capture with timestamp 0.
- Reset mid-LISTEN:
  - Stimulus: assert rst asynchronously, between clock edges, during LISTEN.
  - Required: out_valid=0, busy=0, arrival_ts all-ones immediately; an arm after release starts a clean capture.
